// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Bundles the fetch unit's hazard/branch inputs, the instruction-memory
// request/ready handshake and the IF/ID-facing outputs.
//   master : the fetch unit (drives imem_req/imem_addr and the IF/ID outputs)
//   slave  : the environment (hazard unit, branch unit, memory, IF/ID)
// Signals:
//   stall, branch_taken, branch_target     hazard / redirect inputs
//   imem_req, imem_addr                     memory request
//   imem_ready, imem_rdata                  memory response
//   instruction_out, instr_addr_out,
//   fetch_valid, if_flush, fetch_count      IF/ID side outputs
// ---------------------------------------------------------------------------
interface if_fetch_unit_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 16
);
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instruction_out;
  logic [ADDR_W-1:0]  instr_addr_out;
  logic               fetch_valid;
  logic               if_flush;
  logic [15:0]        fetch_count;

  modport master (
    input  stall, branch_taken, branch_target, imem_ready, imem_rdata,
    output imem_req, imem_addr, instruction_out, instr_addr_out,
           fetch_valid, if_flush, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_ready, imem_rdata,
    input  imem_req, imem_addr, instruction_out, instr_addr_out,
           fetch_valid, if_flush, fetch_count
  );
endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Producer side of the IF/ID pipeline register of the 16-bit RISC core.
// Owns the program counter, requests instructions from instruction memory
// with a ready handshake, and presents each fetched word with its address
// and a valid strobe. Honours stall from the hazard unit and raises a
// one-cycle-per-FLUSH-state if_flush on a taken-branch redirect.
// Ports:
//   clock  : system clock, all state on the rising edge
//   reset  : synchronous, active-high
//   bus    : if_fetch_unit_if.master (handshake, redirect and IF/ID signals)
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_INC   = 1
) (
  input  logic            clock,
  input  logic            reset,
  if_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t             state_q,  state_d;
  logic [ADDR_W-1:0]  pc_q,     pc_d;
  logic [INSTR_W-1:0] instr_q,  instr_d;
  logic [ADDR_W-1:0]  iaddr_q,  iaddr_d;
  logic               valid_q,  valid_d;
  logic               flush_q,  flush_d;
  logic [15:0]        count_q,  count_d;

  logic req;
  logic accept;

  // Word-addressed increment; wraps modulo 2^ADDR_W with no special case.
  function automatic logic [ADDR_W-1:0] pc_advance(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(PC_INC);
  endfunction

  // Request is withheld while an unconsumed instruction is being stalled, so
  // nothing new can overwrite it.
  assign req    = (state_q == FETCH) && !(valid_q && bus.stall);
  // A redirect in the same cycle as a response discards that response.
  assign accept = req && bus.imem_ready && !bus.branch_taken;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    iaddr_d = iaddr_q;
    valid_d = valid_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (bus.branch_taken) begin
          pc_d    = bus.branch_target;
          state_d = FLUSH;
        end else begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.branch_taken) begin
          pc_d    = bus.branch_target;
          valid_d = 1'b0;
          state_d = FLUSH;
        end else if (accept) begin
          instr_d = bus.imem_rdata;
          iaddr_d = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_advance(pc_q);
          count_d = count_q + 16'd1;
        end else if (valid_q && !bus.stall) begin
          valid_d = 1'b0;
        end
      end
      FLUSH: begin
        valid_d = 1'b0;
        // A further redirect keeps the flush going for another cycle.
        if (bus.branch_taken) begin
          pc_d = bus.branch_target;
        end else begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    flush_d = (state_d == FLUSH);
  end

  // ---- IF/ID register boundary ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      iaddr_q <= '0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      iaddr_q <= iaddr_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      count_q <= count_d;
    end
  end

  assign bus.imem_req        = req;
  assign bus.imem_addr       = pc_q;
  assign bus.instruction_out = instr_q;
  assign bus.instr_addr_out  = iaddr_q;
  assign bus.fetch_valid     = valid_q;
  assign bus.if_flush        = flush_q;
  assign bus.fetch_count     = count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  if_fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

  if_fetch_unit #(
    .ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .PC_INC(1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural reference: the fetch unit is "waiting", "fetching" or
  // "flushing"; holding register and counters tracked as plain variables.
  typedef enum int { M_WAIT, M_FETCHING, M_FLUSHING } mphase_t;
  mphase_t     m_phase;
  logic [15:0] m_pc, m_instr, m_iaddr, m_cnt;
  logic        m_valid;

  function automatic logic m_req(input logic stall);
    return (m_phase == M_FETCHING) && !(m_valid && stall);
  endfunction

  task automatic m_reset();
    m_phase = M_WAIT; m_pc = 16'h0000; m_instr = 16'h0; m_iaddr = 16'h0;
    m_valid = 1'b0; m_cnt = 16'h0;
  endtask

  task automatic m_step(input logic rst, input logic stall, input logic br,
                        input logic [15:0] tgt, input logic rdy, input logic [15:0] rdata);
    if (rst) begin
      m_reset();
    end else if (br) begin
      // Redirect wins over everything; the output slot is emptied.
      m_pc = tgt; m_valid = 1'b0; m_phase = M_FLUSHING;
    end else if (m_phase == M_WAIT || m_phase == M_FLUSHING) begin
      m_phase = M_FETCHING;
    end else if (m_req(stall) && rdy) begin
      m_instr = rdata; m_iaddr = m_pc; m_valid = 1'b1;
      m_pc = m_pc + 16'd1; m_cnt = m_cnt + 16'd1;
    end else if (m_valid && !stall) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic compare_model(input logic stall);
    chk("req",   {31'd0, bus.imem_req},    {31'd0, m_req(stall)});
    chk("addr",  {16'd0, bus.imem_addr},   {16'd0, m_pc});
    chk("valid", {31'd0, bus.fetch_valid}, {31'd0, m_valid});
    chk("flush", {31'd0, bus.if_flush},    {31'd0, (m_phase == M_FLUSHING)});
    chk("count", {16'd0, bus.fetch_count}, {16'd0, m_cnt});
    chk("iaddr", {16'd0, bus.instr_addr_out},  {16'd0, m_iaddr});
    chk("instr", {16'd0, bus.instruction_out}, {16'd0, m_instr});
  endtask

  // One clock cycle: drive at negedge, compare #1 later, advance model.
  // Returns before the next posedge so callers may add their own checks.
  task automatic cyc(input logic rst, input logic stall, input logic br,
                     input logic [15:0] tgt, input logic rdy, input logic [15:0] rdata);
    @(negedge clock);
    reset = rst; bus.stall = stall; bus.branch_taken = br;
    bus.branch_target = tgt; bus.imem_ready = rdy; bus.imem_rdata = rdata;
    #1;
    compare_model(stall);
    m_step(rst, stall, br, tgt, rdy, rdata);
  endtask

  typedef struct {
    logic        stall, br, rdy;
    logic [15:0] tgt, rdata;
    logic        e_req, e_valid, e_flush;
    logic [15:0] e_addr, e_iaddr, e_instr, e_cnt;
  } vec_t;

  vec_t vecs[13];
  logic [15:0] saved_cnt;

  initial begin
    // stall br rdy tgt rdata | req valid flush addr iaddr instr cnt
    vecs[0]  = '{0,0,1,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000,16'h0000,16'd0};
    vecs[1]  = '{0,0,1,16'h0000,16'hA000, 1,0,0,16'h0000,16'h0000,16'h0000,16'd0};
    vecs[2]  = '{0,0,1,16'h0000,16'hA001, 1,1,0,16'h0001,16'h0000,16'hA000,16'd1};
    vecs[3]  = '{0,0,1,16'h0000,16'hA002, 1,1,0,16'h0002,16'h0001,16'hA001,16'd2};
    vecs[4]  = '{1,0,1,16'h0000,16'hA003, 0,1,0,16'h0003,16'h0002,16'hA002,16'd3};
    vecs[5]  = '{0,0,0,16'h0000,16'hA003, 1,1,0,16'h0003,16'h0002,16'hA002,16'd3};
    vecs[6]  = '{0,0,1,16'h0000,16'hA003, 1,0,0,16'h0003,16'h0002,16'hA002,16'd3};
    vecs[7]  = '{1,1,1,16'h0040,16'hA004, 0,1,0,16'h0004,16'h0003,16'hA003,16'd4};
    vecs[8]  = '{0,1,1,16'h0100,16'hA040, 0,0,1,16'h0040,16'h0003,16'hA003,16'd4};
    vecs[9]  = '{0,0,1,16'h0000,16'hA041, 0,0,1,16'h0100,16'h0003,16'hA003,16'd4};
    vecs[10] = '{0,0,1,16'h0000,16'hA100, 1,0,0,16'h0100,16'h0003,16'hA003,16'd4};
    vecs[11] = '{0,0,0,16'h0000,16'h0000, 1,1,0,16'h0101,16'h0100,16'hA100,16'd5};
    vecs[12] = '{0,0,0,16'h0000,16'h0000, 1,0,0,16'h0101,16'h0100,16'hA100,16'd5};

    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
    bus.imem_ready = 0; bus.imem_rdata = 0;
    repeat (2) @(posedge clock);
    m_reset();
    cyc(1, 0, 0, 16'h0, 1, 16'h0);   // reset still held: reset values visible

    // Directed table from reset release.
    for (int i = 0; i < 13; i++) begin
      cyc(0, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].rdy, vecs[i].rdata);
      chk($sformatf("v%0d_req", i),   {31'd0, bus.imem_req},    {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_valid", i), {31'd0, bus.fetch_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_flush", i), {31'd0, bus.if_flush},    {31'd0, vecs[i].e_flush});
      chk($sformatf("v%0d_addr", i),  {16'd0, bus.imem_addr},   {16'd0, vecs[i].e_addr});
      chk($sformatf("v%0d_iaddr", i), {16'd0, bus.instr_addr_out},  {16'd0, vecs[i].e_iaddr});
      chk($sformatf("v%0d_instr", i), {16'd0, bus.instruction_out}, {16'd0, vecs[i].e_instr});
      chk($sformatf("v%0d_cnt", i),   {16'd0, bus.fetch_count}, {16'd0, vecs[i].e_cnt});
    end

    // Reset mid-wait with an outstanding request, then a late ready.
    cyc(0, 0, 0, 16'h0, 0, 16'h0);
    chk("midrst_req_before", {31'd0, bus.imem_req}, 32'd1);
    cyc(1, 0, 0, 16'h0, 0, 16'h0);
    cyc(0, 0, 0, 16'h0, 1, 16'hDEAD);
    chk("midrst_req",   {31'd0, bus.imem_req},    32'd0);
    chk("midrst_valid", {31'd0, bus.fetch_valid}, 32'd0);
    chk("midrst_cnt",   {16'd0, bus.fetch_count}, 32'd0);
    chk("midrst_instr", {16'd0, bus.instruction_out}, 32'd0);
    cyc(0, 0, 0, 16'h0, 0, 16'h0);
    chk("late_rdy_valid", {31'd0, bus.fetch_valid}, 32'd0);
    chk("late_rdy_cnt",   {16'd0, bus.fetch_count}, 32'd0);
    chk("late_rdy_addr",  {16'd0, bus.imem_addr},   32'd0);

    // Branch to 0xFFFF then observe the wrap to 0x0000.
    cyc(0, 0, 1, 16'hFFFF, 0, 16'h0);
    cyc(0, 0, 0, 16'h0, 0, 16'h0);
    chk("wrap_flush", {31'd0, bus.if_flush}, 32'd1);
    cyc(0, 0, 0, 16'h0, 1, 16'h1234);
    chk("wrap_addr_ffff", {16'd0, bus.imem_addr}, 32'h0000FFFF);
    cyc(0, 0, 0, 16'h0, 1, 16'h5678);
    chk("wrap_iaddr", {16'd0, bus.instr_addr_out}, 32'h0000FFFF);
    chk("wrap_addr_0", {16'd0, bus.imem_addr}, 32'h00000000);
    cyc(0, 0, 0, 16'h0, 0, 16'h0);
    chk("wrap_iaddr0", {16'd0, bus.instr_addr_out}, 32'h00000000);
    chk("wrap_instr0", {16'd0, bus.instruction_out}, 32'h00005678);

    // Redirect coincident with a memory response: response discarded.
    saved_cnt = m_cnt;
    cyc(0, 0, 1, 16'h0040, 1, 16'hBEEF);
    cyc(0, 0, 0, 16'h0, 0, 16'h0);
    chk("brrdy_flush", {31'd0, bus.if_flush},    32'd1);
    chk("brrdy_valid", {31'd0, bus.fetch_valid}, 32'd0);
    chk("brrdy_cnt",   {16'd0, bus.fetch_count}, {16'd0, saved_cnt});
    cyc(0, 0, 0, 16'h0, 1, 16'h0);
    chk("brrdy_flush_end", {31'd0, bus.if_flush}, 32'd0);
    chk("brrdy_next_addr", {16'd0, bus.imem_addr}, 32'h00000040);

    // Randomised run against the reference model.
    for (int n = 0; n < 1500; n++) begin
      cyc(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 25),
          ($urandom_range(0, 99) < 5), 16'($urandom), ($urandom_range(0, 99) < 60),
          16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
